// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch-stage package: fetch FSM state encoding,
// NOP encoding and the default reset PC.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HAVE = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  localparam logic [31:0] MIPS_NOP     = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/grant/response bundle.
// master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, runs one
// outstanding imem transaction, feeds IF/ID with bubbles.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   Stall,
  input  logic                   Redirect,
  input  logic [31:0]            Redirect_Target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            IF_PC_plus_4,
  output logic [31:0]            IF_Instruction,
  output logic                   IF_Flush
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  inst_buf, buf_n;
  logic [31:0]  pc_plus_4;

  assign pc_plus_4 = pc + 32'd4;

  // Next-state, next-PC and buffer capture; redirect overrides PC.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    buf_n   = inst_buf;
    unique case (1'b1)
      (state == S_REQ): begin
        if (imem.imem_gnt)
          state_n = Redirect ? S_DROP : S_WAIT;
      end
      (state == S_WAIT): begin
        if (imem.imem_rvalid) begin
          if (Redirect) begin
            state_n = S_REQ;
          end else begin
            buf_n   = imem.imem_rdata;
            state_n = S_HAVE;
          end
        end else if (Redirect) begin
          state_n = S_DROP;
        end
      end
      (state == S_HAVE): begin
        if (Redirect) begin
          state_n = S_REQ;
        end else if (!Stall) begin
          pc_n    = pc_plus_4;
          state_n = S_REQ;
        end
      end
      default: begin
        if (imem.imem_rvalid)
          state_n = S_REQ;
      end
    endcase
    if (Redirect)
      pc_n = Redirect_Target;
  end

  // State, PC and instruction buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      inst_buf <= MIPS_NOP;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      inst_buf <= buf_n;
    end
  end

  assign imem.imem_req  = reset_n & (state == S_REQ);
  assign imem.imem_addr = pc;

  assign IF_PC_plus_4   = pc_plus_4;
  assign IF_Instruction = (state == S_HAVE) ? inst_buf
                                            : MIPS_NOP;
  assign IF_Flush       = Redirect |
                          ((state != S_HAVE) & ~Stall);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random
// traffic, checked against a transaction-level PC model.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset_n;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic [31:0] IF_PC_plus_4;
  logic [31:0] IF_Instruction;
  logic        IF_Flush;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .Stall           (Stall),
    .Redirect        (Redirect),
    .Redirect_Target (Redirect_Target),
    .imem            (bus),
    .IF_PC_plus_4    (IF_PC_plus_4),
    .IF_Instruction  (IF_Instruction),
    .IF_Flush        (IF_Flush)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // reference model: architectural fetch view
  logic [31:0] m_pc;
  logic        m_have;
  logic [31:0] m_data;
  logic        m_out;
  logic        m_stale;

  // memory model
  logic        mem_busy;
  int          mem_cnt;
  int          mem_dly;
  logic [31:0] mem_addr;
  logic        ovr_en;
  logic [31:0] ovr_val;

  // last observations
  logic        obs_req;
  logic [31:0] obs_addr;
  logic [31:0] obs_inst;
  logic        obs_flush;
  logic [31:0] granted[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RST_PC;
    m_have   = 1'b0;
    m_data   = 32'h0;
    m_out    = 1'b0;
    m_stale  = 1'b0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    ovr_en   = 1'b0;
  endtask

  // one clock cycle; entered and left just after a negedge
  task automatic step(input logic st, input logic rd,
                      input logic [31:0] tg, input bit g);
    logic        gnt, rv, cons;
    logic [31:0] rdat;
    Stall = st;
    Redirect = rd;
    Redirect_Target = tg;
    #1;
    obs_req  = bus.imem_req;
    obs_addr = bus.imem_addr;
    gnt  = g && obs_req && !mem_busy;
    rv   = mem_busy && (mem_cnt == 0);
    rdat = $urandom;
    if (rv) rdat = ovr_en ? ovr_val : word(mem_addr);
    bus.imem_gnt    = gnt;
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rdat;
    #1;
    obs_inst  = IF_Instruction;
    obs_flush = IF_Flush;
    chk1("req", obs_req, !m_out && !m_have);
    if (!m_out && !m_have) chk("addr", obs_addr, m_pc);
    chk("pc4", IF_PC_plus_4, m_pc + 32'd4);
    chk("inst", obs_inst, m_have ? m_data : 32'h0);
    chk1("flush", obs_flush, rd | (!m_have & !st));
    if (rv) chk1("proto", m_out, 1'b1);
    @(posedge clk);
    cons = m_have && !st && !rd;
    if (rd) begin
      m_pc   = tg;
      m_have = 1'b0;
    end else if (cons) begin
      m_pc   = m_pc + 32'd4;
      m_have = 1'b0;
    end
    if (rv) begin
      if (!m_stale && !rd) begin
        m_have = 1'b1;
        m_data = rdat;
      end
      m_out   = 1'b0;
      m_stale = 1'b0;
    end
    if (gnt) begin
      m_out   = 1'b1;
      m_stale = rd;
    end else if (rd && m_out) begin
      m_stale = 1'b1;
    end
    if (rv) begin
      mem_busy = 1'b0;
      ovr_en   = 1'b0;
    end else if (mem_busy) begin
      mem_cnt--;
    end
    if (gnt) begin
      mem_busy = 1'b1;
      mem_addr = obs_addr;
      mem_cnt  = mem_dly;
      granted.push_back(obs_addr);
    end
    @(negedge clk);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
  endtask

  task automatic do_reset(input logic st);
    Stall = st;
    Redirect = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk1("rst_req", bus.imem_req, 1'b0);
    chk("rst_pc4", IF_PC_plus_4, RST_PC + 32'd4);
    chk("rst_inst", IF_Instruction, 32'h0);
    chk1("rst_flush", IF_Flush, !st);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_req_hold", bus.imem_req, 1'b0);
    reset_n = 1'b1;
    model_reset();
    #1;
    chk1("rel_req", bus.imem_req, 1'b1);
    @(negedge clk);
  endtask

  task automatic settle();
    int n = 0;
    while ((m_out || m_have) && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b0);
      n++;
    end
    chk1("settle_to", m_out || m_have, 1'b0);
  endtask

  task automatic wait_have(input logic st);
    int n = 0;
    while (!m_have && n < 20) begin
      step(st, 1'b0, 32'h0, 1'b1);
      if (st) chk1("stall_noflush", obs_flush, 1'b0);
      n++;
    end
    chk1("have_to", m_have, 1'b1);
  endtask

  initial begin
    int fcount;
    logic [31:0] pcb, tg;
    reset_n = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    Redirect_Target = 32'h0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = 32'h0;
    mem_dly = 0;
    mem_addr = 32'h0;
    ovr_val = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset(1'b0);

    // zero-wait streaming
    fcount = 0;
    granted.delete();
    repeat (9) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_flush) fcount++;
    end
    chk("flush_cnt", fcount, 6);
    chk("gaddr0", granted[0], 32'h0);
    chk("gaddr1", granted[1], 32'h4);
    chk("gaddr2", granted[2], 32'h8);

    // stall while presenting
    settle();
    ovr_en = 1'b1;
    ovr_val = 32'h8C01_0004;
    wait_have(1'b0);
    pcb = m_pc;
    repeat (4) begin
      step(1'b1, 1'b0, 32'h0, 1'b1);
      chk("stall_inst", obs_inst, 32'h8C01_0004);
      chk1("stall_flush", obs_flush, 1'b0);
    end
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("stall_adv", IF_PC_plus_4, pcb + 32'd8);

    // stall while waiting on a slow response
    settle();
    mem_dly = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    wait_have(1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // redirect while waiting: stale data dropped
    settle();
    mem_dly = 1;
    ovr_en = 1'b1;
    ovr_val = 32'hDEAD_BEEF;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b0);
    settle();
    mem_dly = 0;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_addr", obs_addr, 32'h100);
    wait_have(1'b0);
    chk1("no_dbf", obs_inst == 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);

    // redirect with grant in the same cycle
    settle();
    mem_dly = 1;
    ovr_en = 1'b1;
    ovr_val = 32'hDEAD_BEEF;
    step(1'b0, 1'b1, 32'h100, 1'b1);
    settle();
    mem_dly = 0;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("drop_addr", obs_addr, 32'h100);
    wait_have(1'b0);
    chk1("no_dbf2", obs_inst == 32'hDEAD_BEEF, 1'b0);

    // PC wrap at top of address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_have(1'b0);
    chk("wrap_pc4", IF_PC_plus_4, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_next", IF_PC_plus_4, 32'h4);

    // reset in the middle of a transaction
    settle();
    mem_dly = 3;
    step(1'b0, 1'b0, 32'h0, 1'b1);
    do_reset(1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset(1'b1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      mem_dly = $urandom_range(0, 3);
      tg = $urandom;
      tg[1:0] = 2'b00;
      step($urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0,
           tg,
           $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
